ssds_scan_driver: RTL
=====================

# ssds_scan_driver

Time-multiplexed scan driver for a 4-digit, common-anode seven-segment display. Sits directly downstream of the SSD bus interface. It consumes that block's enable, four decoded 7-bit segment patterns and four dot bits, and drives the shared segment lines and per-digit anode lines of the physical display. It owns refresh timing, inter-digit blanking (anti-ghosting) and per-slot snapshotting of the digit data.

## Interface
Parameters:
- `DIVIDER`, default 50000: clock cycles per digit slot; full refresh period = 4·DIVIDER. Must be ≥ BLANK_CYCLES+2.
- `BLANK_CYCLES`, default 64: cycles at the start of each slot during which all anodes are off.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: display enable, from the bus interface control bit.
- `digit_0`..`digit_3` in 7 each: segment patterns, active-high (1 = lit), bit 0 = segment a … bit 6 = segment g.
- `dots` in 4: decimal points, active-high; bit i belongs to digit i.
- `brightness` in 4: present only with SSDS_BRIGHTNESS_EN; 0 = off, 15 = full.
- `seg_out` out 7: segment cathodes, active-low.
- `dp_out` out 1: decimal-point cathode, active-low.
- `an_out` out 4: digit anodes, active-low; bit i selects digit i.

## Operation
- State:
  - `slot_cnt`, 0..DIVIDER-1, width $clog2(DIVIDER).
  - `digit_idx`, 2 bits.
  - Snapshot register: 7 segment bits + 1 dot bit.
- Slot counter:
  - When en=1, `slot_cnt` increments every cycle.
  - At DIVIDER-1 it wraps to 0 and `digit_idx` increments, wrapping 3→0.
  - Scan order is 0,1,2,3,0,…
- Snapshot:
  - When slot_cnt==0, the driver captures `digit_[digit_idx]` and `dots[digit_idx]`.
  - Input changes mid-slot are never visible until the next slot of that digit.
- Output phases within a slot:
  - Blank phase, slot_cnt < BLANK_CYCLES: an_out=4'b1111, seg_out=7'h7F, dp_out=1.
  - Lit phase, slot_cnt ≥ BLANK_CYCLES: an_out = ~(4'b0001 << digit_idx), seg_out = ~snapshot segments, dp_out = ~snapshot dot.
- en=0:
  - slot_cnt and digit_idx are held at 0.
  - All outputs are at their blank values.
  - On en 0→1, scanning restarts at digit 0 with a full blank phase.
- en falling mid-slot: outputs blank on the next registered update and counters return to 0. The partial slot is not resumed.
- An all-zero pattern is still scanned: anode active, no segments lit. This is not treated as en=0.

## Timing
- All outputs are registered and are derived from the counter state of the previous cycle, so response lags state by exactly 1 cycle.
- Reset values:
  - an_out = 4'b1111, seg_out = 7'h7F, dp_out = 1.
  - slot_cnt = 0, digit_idx = 0, snapshot = 0.
- After rst deassertion with en=1: the first lit cycle of digit 0 is BLANK_CYCLES+1 cycles after the first clock edge.
- Per slot:
  - Exactly DIVIDER-BLANK_CYCLES lit cycles and BLANK_CYCLES blank cycles.
  - Only one anode is ever active at a time.
  - Never two different anodes active in consecutive cycles without ≥ BLANK_CYCLES blank cycles between them.
- Snapshot-to-output latency: the pattern captured at slot_cnt==0 first appears on seg_out BLANK_CYCLES+1 cycles later.
- rst asserted mid-slot: outputs go to reset values immediately (asynchronously).

## Configuration
- `SSDS_BRIGHTNESS_EN` defined:
  - Adds the `brightness` port and a free-running 4-bit PWM counter, reset 0, that counts only while en=1.
  - During the lit phase the anode is active only when pwm_cnt < brightness. brightness=15 forces always-on.
  - Segment and dot outputs follow the same gating, so they are blank whenever the anode is off.
  - brightness is sampled every cycle, with no snapshot.
- Undefined: no `brightness` port and no PWM logic; the lit phase is fully on.

## Test plan
- DIVIDER=8, BLANK_CYCLES=2, en=1, digits 7'h06/7'h5B/7'h4F/7'h66, dots=4'b0101 → scan period 32 cycles. Each digit gets 6 lit cycles with the correct ~pattern on seg_out; dp_out=0 only while digits 0 and 2 are lit. All anodes are off for 2 cycles per slot.
- Change digit_1 from 7'h5B to 7'h7F while digit 1 is lit → seg_out holds ~7'h5B until that slot ends; the next digit-1 slot shows 7'h00.
- en 1→0 mid-slot of digit 2 → the next cycle shows an_out=4'hF, seg_out=7'h7F. On en 0→1, digit 0 is lit after exactly 3 cycles.
- Assert rst asynchronously mid-lit-phase → outputs reach reset values before the next clk edge. After release, scanning restarts at digit 0.
- Over 1000 cycles with random inputs → an_out is never other than 4'hF or a single zero bit.
- With SSDS_BRIGHTNESS_EN, brightness=4 → lit cycles per 16-cycle PWM window within the lit phase = 4. brightness=0 → no anode ever active. brightness=15 → identical to the macro-undefined build.

Source files
------------

// File: rtl/ssds_scan_driver.sv
// Scan driver for a 4-digit common-anode seven-segment display: refresh timing, inter-digit blanking, per-slot snapshot.
// Optional PWM dimming with a brightness port is enabled by defining SSDS_BRIGHTNESS_EN.
module ssds_scan_driver #(
   parameter int DIVIDER      = 50000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [6:0] digit_0,
   input  logic [6:0] digit_1,
   input  logic [6:0] digit_2,
   input  logic [6:0] digit_3,
   input  logic [3:0] dots,
`ifdef SSDS_BRIGHTNESS_EN
   input  logic [3:0] brightness,
`endif
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic [3:0] an_out
);

   localparam int            CW    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST  = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

   logic [CW-1:0] slot_cnt;
   logic [1:0]    digit_idx;
   logic [6:0]    snap_seg;
   logic          snap_dot;
   logic [6:0]    cur_seg;
   logic [6:0]    lit_seg;
   logic          lit_dot;
   logic          pwm_on;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;
   logic [3:0]    an_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (!en) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (slot_cnt == LAST) begin
         slot_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         slot_cnt  <= slot_cnt + CW'(1);
      end
   end

   always_comb begin
      case (digit_idx)
         2'd0:    cur_seg = digit_0;
         2'd1:    cur_seg = digit_1;
         2'd2:    cur_seg = digit_2;
         default: cur_seg = digit_3;
      endcase
   end

   // Data is frozen at the first cycle of a slot so mid-slot bus writes cannot tear the digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_seg <= '0;
         snap_dot <= 1'b0;
      end else if (en && slot_cnt == '0) begin
         snap_seg <= cur_seg;
         snap_dot <= dots[digit_idx];
      end
   end

   // Bypass the snapshot in the capture cycle itself, which only matters when BLANK_CYCLES is 0.
   assign lit_seg = (slot_cnt == '0) ? cur_seg : snap_seg;
   assign lit_dot = (slot_cnt == '0) ? dots[digit_idx] : snap_dot;

`ifdef SSDS_BRIGHTNESS_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     pwm_cnt <= '0;
      else if (en) pwm_cnt <= pwm_cnt + 4'd1;
   end

   assign pwm_on = (brightness == 4'hF) || (pwm_cnt < brightness);
`else
   assign pwm_on = 1'b1;
`endif

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      if (en && slot_cnt >= BLANK && pwm_on) begin
         an_nxt  = ~(4'b0001 << digit_idx);
         seg_nxt = ~lit_seg;
         dp_nxt  = ~lit_dot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_out  <= 4'b1111;
         seg_out <= 7'h7F;
         dp_out  <= 1'b1;
      end else begin
         an_out  <= an_nxt;
         seg_out <= seg_nxt;
         dp_out  <= dp_nxt;
      end
   end

endmodule
